// File: rtl/usb_tx_buffer.sv
// Byte FIFO that drains to an FT245-style parallel write port (TXE# / WR),
// sequencing setup, strobe and recovery time for every byte.
module usb_tx_buffer #(
    parameter int Depth         = 64,
    parameter int SetupCycles   = 2,
    parameter int PulseCycles   = 4,
    parameter int RecoverCycles = 6
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset,
    input  logic [7:0]               i_DataIn,
    input  logic                     i_WrReq,
    input  logic                     i_UsbTxe_n,
    output logic [7:0]               o_UsbData,
    output logic                     o_UsbDataOE,
    output logic                     o_UsbWr,
    output logic [$clog2(Depth):0]   o_FifoLevel,
    output logic                     o_Overflow,
    output logic                     o_Busy
);
    localparam int AW   = $clog2(Depth);
    localparam int MAXA = (SetupCycles > PulseCycles) ? SetupCycles : PulseCycles;
    localparam int MAXC = (MAXA > RecoverCycles) ? MAXA : RecoverCycles;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [AW:0]   LVL_FULL  = (AW+1)'(Depth);
    localparam logic [CW-1:0] C_SETUP   = CW'(SetupCycles - 1);
    localparam logic [CW-1:0] C_PULSE   = CW'(PulseCycles - 1);
    localparam logic [CW-1:0] C_RECOVER = CW'(RecoverCycles - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_RECOVER} state_t;

    state_t          r_state, w_state;
    logic [CW-1:0]   r_cnt, w_cnt;
    logic            r_wr, w_wr;
    logic            r_oe, w_oe;
    logic            w_pop, w_push;
    logic [7:0]      r_data;
    logic [7:0]      r_mem [Depth];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [AW:0]     r_level;
    logic            r_overflow;
    logic            r_txe_m, r_txe_s;

    // Full is judged on the registered level, so a same-cycle pop never frees room.
    assign w_push = i_WrReq && (r_level != LVL_FULL);

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_wr    = 1'b0;
        w_oe    = 1'b0;
        w_pop   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_level != '0 && !r_txe_s) begin
                    w_pop   = 1'b1;
                    w_oe    = 1'b1;
                    w_cnt   = C_SETUP;
                    w_state = S_SETUP;
                end
            end
            S_SETUP: begin
                w_oe = 1'b1;
                if (r_cnt == '0) begin
                    w_wr    = 1'b1;
                    w_cnt   = C_PULSE;
                    w_state = S_STROBE;
                end else begin
                    w_cnt = r_cnt - 1'b1;
                end
            end
            S_STROBE: begin
                // OE carried into the first RECOVER cycle holds data past WR fall.
                w_oe = 1'b1;
                w_wr = 1'b1;
                if (r_cnt == '0) begin
                    w_wr    = 1'b0;
                    w_cnt   = C_RECOVER;
                    w_state = S_RECOVER;
                end else begin
                    w_cnt = r_cnt - 1'b1;
                end
            end
            S_RECOVER: begin
                if (r_cnt == '0) w_state = S_IDLE;
                else             w_cnt   = r_cnt - 1'b1;
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_wr       <= 1'b0;
            r_oe       <= 1'b0;
            r_data     <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_txe_m    <= 1'b1;
            r_txe_s    <= 1'b1;
        end else begin
            r_txe_m <= i_UsbTxe_n;
            r_txe_s <= r_txe_m;
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_wr    <= w_wr;
            r_oe    <= w_oe;
            if (w_pop) begin
                r_data   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push)             r_wr_ptr   <= r_wr_ptr + 1'b1;
            if (i_WrReq && !w_push) r_overflow <= 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset && w_push) r_mem[r_wr_ptr] <= i_DataIn;
    end

    assign o_UsbData   = r_data;
    assign o_UsbDataOE = r_oe;
    assign o_UsbWr     = r_wr;
    assign o_FifoLevel = r_level;
    assign o_Overflow  = r_overflow;
    assign o_Busy      = (r_level != '0) || (r_state != S_IDLE);
endmodule
